// File: rtl/bram_arb_pkg.sv
// Shared definitions for the frame-BRAM port arbiter: requester IDs,
// read-return tag encoding and the address-width helper.
package bram_arb_pkg;

    localparam int REQ_LD = 0;
    localparam int REQ_CV = 1;
    localparam int REQ_HS = 2;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CV   = 2'd1,
        TAG_HS   = 2'd2
    } tag_e;

    // Number of bits needed to represent 'value' (clogb2(65535) = 16).
    function automatic int clogb2(input int value);
        int bits;
        bits = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant with an exclude mask. The pointer remembers the
// last granted requester and only moves when a grant (a transfer) is issued.
module rr_arbiter3 (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] i_req,
    input  logic [2:0] i_excl,
    output logic [2:0] o_gnt
);

    logic [1:0] r_last;
    logic [2:0] w_mask;

    assign w_mask = i_req & ~i_excl;

    always_comb begin
        o_gnt = 3'b000;
        case (r_last)
            2'd0: begin
                if      (w_mask[1]) o_gnt = 3'b010;
                else if (w_mask[2]) o_gnt = 3'b100;
                else if (w_mask[0]) o_gnt = 3'b001;
            end
            2'd1: begin
                if      (w_mask[2]) o_gnt = 3'b100;
                else if (w_mask[0]) o_gnt = 3'b001;
                else if (w_mask[1]) o_gnt = 3'b010;
            end
            default: begin
                if      (w_mask[0]) o_gnt = 3'b001;
                else if (w_mask[1]) o_gnt = 3'b010;
                else if (w_mask[2]) o_gnt = 3'b100;
            end
        endcase
    end

    // Reset to requester 2 so the loader (0) wins the first search.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 2'd2;
        end else if (|o_gnt) begin
            r_last <= o_gnt[0] ? 2'd0 : (o_gnt[1] ? 2'd1 : 2'd2);
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port no-change frame BRAM between the loader (write), the
// conv window reader and the host readout, returning read data by tag.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_DEPTH  = 65536,
    parameter int RD_LATENCY = 1,
    parameter int LOCK_MAX   = 3,
    localparam int ADDR_W    = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_ld_valid,
    output logic                 o_ld_ready,
    input  logic [ADDR_W-1:0]    i_ld_addr,
    input  logic [RAM_WIDTH-1:0] i_ld_data,
    input  logic                 i_cv_valid,
    output logic                 o_cv_ready,
    input  logic [ADDR_W-1:0]    i_cv_addr,
    input  logic                 i_cv_lock,
    output logic                 o_cv_rvalid,
    output logic [RAM_WIDTH-1:0] o_cv_rdata,
    input  logic                 i_hs_valid,
    output logic                 o_hs_ready,
    input  logic [ADDR_W-1:0]    i_hs_addr,
    output logic                 o_hs_rvalid,
    output logic [RAM_WIDTH-1:0] o_hs_rdata,
    output logic                 o_ram_ena,
    output logic                 o_ram_wea,
    output logic [ADDR_W-1:0]    o_ram_addr,
    output logic [RAM_WIDTH-1:0] o_ram_din,
    output logic                 o_ram_regcea,
    input  logic [RAM_WIDTH-1:0] i_ram_douta,
    output logic                 o_busy
);

    localparam int CNT_W = clogb2(LOCK_MAX);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_MAX);

    logic [2:0]           w_req;
    logic [2:0]           w_excl;
    logic [2:0]           w_gnt;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_pipe_busy;

    logic                 r_locked;
    logic [CNT_W-1:0]     r_lock_cnt;
    logic                 r_cv_excl;
    logic                 r_ena;
    logic                 r_wea;
    logic [ADDR_W-1:0]    r_addr;
    logic [RAM_WIDTH-1:0] r_din;
    tag_e                 r_cmd_tag;
    tag_e                 r_tag_pipe [0:RD_LATENCY-1];
    logic                 r_cv_rvalid;
    logic                 r_hs_rvalid;

    assign w_req = {i_hs_valid, i_cv_valid, i_ld_valid};

    // While locked only cv may win; right after a forced release cv sits out
    // one arbitration, but only if someone else is actually waiting.
    always_comb begin
        w_excl = 3'b000;
        if (r_locked) begin
            w_excl[REQ_LD] = 1'b1;
            w_excl[REQ_HS] = 1'b1;
        end else if (r_cv_excl && (i_ld_valid || i_hs_valid)) begin
            w_excl[REQ_CV] = 1'b1;
        end
    end

    rr_arbiter3 u_rr (
        .clk    (clk),
        .reset  (reset),
        .i_req  (w_req),
        .i_excl (w_excl),
        .o_gnt  (w_gnt)
    );

    assign o_ld_ready = w_gnt[REQ_LD];
    assign o_cv_ready = w_gnt[REQ_CV];
    assign o_hs_ready = w_gnt[REQ_HS];

    assign w_cnt_next = r_locked ? (r_lock_cnt + CNT_W'(1)) : CNT_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
            r_cv_excl  <= 1'b0;
        end else begin
            r_cv_excl <= 1'b0;
            if (w_gnt[REQ_CV] && i_cv_lock) begin
                if (w_cnt_next == LOCK_LAST) begin
                    r_locked   <= 1'b0;
                    r_lock_cnt <= '0;
                    r_cv_excl  <= 1'b1;
                end else begin
                    r_locked   <= 1'b1;
                    r_lock_cnt <= w_cnt_next;
                end
            end else if (r_locked && !i_cv_lock) begin
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end
        end
    end

    // Address and write data hold between transfers; din only follows loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ena     <= 1'b0;
            r_wea     <= 1'b0;
            r_addr    <= '0;
            r_din     <= '0;
            r_cmd_tag <= TAG_NONE;
        end else begin
            r_ena     <= |w_gnt;
            r_wea     <= w_gnt[REQ_LD];
            r_cmd_tag <= w_gnt[REQ_CV] ? TAG_CV : (w_gnt[REQ_HS] ? TAG_HS : TAG_NONE);
            if (w_gnt[REQ_LD]) begin
                r_addr <= i_ld_addr;
                r_din  <= i_ld_data;
            end else if (w_gnt[REQ_CV]) begin
                r_addr <= i_cv_addr;
            end else if (w_gnt[REQ_HS]) begin
                r_addr <= i_hs_addr;
            end
        end
    end

    // Tag leaves the last stage together with the RAM data; RD_LATENCY is 1 or 2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_tag_pipe[i] <= TAG_NONE;
            end
            r_cv_rvalid <= 1'b0;
            r_hs_rvalid <= 1'b0;
        end else begin
            r_tag_pipe[0] <= r_cmd_tag;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
            r_cv_rvalid <= (r_tag_pipe[RD_LATENCY-1] == TAG_CV);
            r_hs_rvalid <= (r_tag_pipe[RD_LATENCY-1] == TAG_HS);
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_pipe_busy = w_pipe_busy | (r_tag_pipe[i] != TAG_NONE);
        end
    end

    assign o_ram_ena    = r_ena;
    assign o_ram_wea    = r_wea;
    assign o_ram_addr   = r_addr;
    assign o_ram_din    = r_din;
    assign o_ram_regcea = reset;
    assign o_cv_rvalid  = r_cv_rvalid;
    assign o_hs_rvalid  = r_hs_rvalid;
    assign o_cv_rdata   = i_ram_douta;
    assign o_hs_rdata   = i_ram_douta;
    assign o_busy       = r_ena | w_pipe_busy;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench driving two arbiters (RD_LATENCY 1 and 2) with shared stimulus;
// expected read returns go into per-DUT queues checked by a negedge monitor.
module tb_bram_port_arbiter;

    localparam int AW = 16;

    typedef struct {
        logic [1:0] tgt;
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic          ld_valid, cv_valid, cv_lock, hs_valid;
    logic [AW-1:0] ld_addr, cv_addr, hs_addr;
    logic [7:0]    ld_data;

    logic          d1_ld_ready, d1_cv_ready, d1_hs_ready, d1_cv_rvalid, d1_hs_rvalid;
    logic [7:0]    d1_cv_rdata, d1_hs_rdata, d1_din;
    logic          d1_ena, d1_wea, d1_regcea, d1_busy;
    logic [AW-1:0] d1_addr;
    logic          d2_ld_ready, d2_cv_ready, d2_hs_ready, d2_cv_rvalid, d2_hs_rvalid;
    logic [7:0]    d2_cv_rdata, d2_hs_rdata, d2_din;
    logic          d2_ena, d2_wea, d2_regcea, d2_busy;
    logic [AW-1:0] d2_addr;

    logic [7:0] mem1 [0:65535];
    logic [7:0] mem2 [0:65535];
    bit         wr1  [0:65535];
    bit         wr2  [0:65535];
    bit         p1v = 1'b0;
    logic [7:0] p1d = '0;
    bit   [1:0] p2v = '0;
    logic [7:0] p2d [0:1];
    logic [7:0] dout1 = '0;
    logic [7:0] dout2 = '0;

    exp_t       q1[$];
    exp_t       q2[$];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] expDin;
    logic [AW-1:0] expAddr;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bram_port_arbiter #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .i_ld_valid(ld_valid), .o_ld_ready(d1_ld_ready), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .i_cv_valid(cv_valid), .o_cv_ready(d1_cv_ready), .i_cv_addr(cv_addr), .i_cv_lock(cv_lock),
        .o_cv_rvalid(d1_cv_rvalid), .o_cv_rdata(d1_cv_rdata),
        .i_hs_valid(hs_valid), .o_hs_ready(d1_hs_ready), .i_hs_addr(hs_addr),
        .o_hs_rvalid(d1_hs_rvalid), .o_hs_rdata(d1_hs_rdata),
        .o_ram_ena(d1_ena), .o_ram_wea(d1_wea), .o_ram_addr(d1_addr), .o_ram_din(d1_din),
        .o_ram_regcea(d1_regcea), .i_ram_douta(dout1), .o_busy(d1_busy)
    );

    bram_port_arbiter #(.RD_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset),
        .i_ld_valid(ld_valid), .o_ld_ready(d2_ld_ready), .i_ld_addr(ld_addr), .i_ld_data(ld_data),
        .i_cv_valid(cv_valid), .o_cv_ready(d2_cv_ready), .i_cv_addr(cv_addr), .i_cv_lock(cv_lock),
        .o_cv_rvalid(d2_cv_rvalid), .o_cv_rdata(d2_cv_rdata),
        .i_hs_valid(hs_valid), .o_hs_ready(d2_hs_ready), .i_hs_addr(hs_addr),
        .o_hs_rvalid(d2_hs_rvalid), .o_hs_rdata(d2_hs_rdata),
        .o_ram_ena(d2_ena), .o_ram_wea(d2_wea), .o_ram_addr(d2_addr), .o_ram_din(d2_din),
        .o_ram_regcea(d2_regcea), .i_ram_douta(dout2), .o_busy(d2_busy)
    );

    // Unwritten locations read as a fixed preload pattern: mem[a] = a[7:0] + 0x10.
    function automatic logic [7:0] patt(input logic [AW-1:0] a);
        return a[7:0] + 8'h10;
    endfunction

    // RAM models: command seen at edge n is sampled at n+1 and douta updates at
    // edge n+1+RD_LATENCY, holding its value otherwise (no-change mode).
    always @(posedge clk) begin
        if (p1v) dout1 <= p1d;
        p1v <= d1_ena && !d1_wea;
        p1d <= wr1[d1_addr] ? mem1[d1_addr] : patt(d1_addr);
        if (d1_ena && d1_wea) begin
            mem1[d1_addr] <= d1_din;
            wr1[d1_addr]  <= 1'b1;
        end
    end

    always @(posedge clk) begin
        if (p2v[1]) dout2 <= p2d[1];
        p2v[1] <= p2v[0];
        p2d[1] <= p2d[0];
        p2v[0] <= d2_ena && !d2_wea;
        p2d[0] <= wr2[d2_addr] ? mem2[d2_addr] : patt(d2_addr);
        if (d2_ena && d2_wea) begin
            mem2[d2_addr] <= d2_din;
            wr2[d2_addr]  <= 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [AW-1:0] la, input logic [7:0] ldat,
                                 input logic cvv, input logic [AW-1:0] ca, input logic lk,
                                 input logic hv, input logic [AW-1:0] ha);
        ld_valid = lv;  ld_addr = la;  ld_data = ldat;
        cv_valid = cvv; cv_addr = ca;  cv_lock = lk;
        hs_valid = hv;  hs_addr = ha;
    endtask

    task automatic stepClk;
        @(posedge clk);
        #1;
    endtask

    // g: 0 = ld, 1 = cv, 2 = hs, 3 = nobody ready
    task automatic checkReady(input string n, input int g);
        checkOutput({n, "_d1_ld_ready"}, d1_ld_ready, g == 0);
        checkOutput({n, "_d1_cv_ready"}, d1_cv_ready, g == 1);
        checkOutput({n, "_d1_hs_ready"}, d1_hs_ready, g == 2);
        checkOutput({n, "_d2_ld_ready"}, d2_ld_ready, g == 0);
        checkOutput({n, "_d2_cv_ready"}, d2_cv_ready, g == 1);
        checkOutput({n, "_d2_hs_ready"}, d2_hs_ready, g == 2);
    endtask

    task automatic checkCmd(input string n, input logic ena, input logic wea,
                            input logic [AW-1:0] addr, input logic [7:0] din);
        checkOutput({n, "_d1_ena"},  d1_ena,  ena);
        checkOutput({n, "_d1_wea"},  d1_wea,  wea);
        checkOutput({n, "_d1_addr"}, d1_addr, addr);
        checkOutput({n, "_d1_din"},  d1_din,  din);
        checkOutput({n, "_d2_ena"},  d2_ena,  ena);
        checkOutput({n, "_d2_wea"},  d2_wea,  wea);
        checkOutput({n, "_d2_addr"}, d2_addr, addr);
        checkOutput({n, "_d2_din"},  d2_din,  din);
    endtask

    // Called before the edge that carries the transfer (edge cyc+1).
    task automatic expectRead(input logic [1:0] tgt, input logic [7:0] data);
        q1.push_back('{tgt: tgt, data: data, due: cyc + 3});
        q2.push_back('{tgt: tgt, data: data, due: cyc + 4});
    endtask

    function automatic logic [AW-1:0] seqAddr(input int g, input int k);
        case (g)
            0:       return 16'h0300 + AW'(k);
            1:       return 16'h0100 + AW'(k);
            default: return 16'h0200 + AW'(k);
        endcase
    endfunction

    task automatic doReset;
        reset = 1'b0;
        q1.delete();
        q2.delete();
        stepClk;
        @(negedge clk);
        reset = 1'b1;
        stepClk;
    endtask

    task automatic monitorDut(input int d, input logic cvv, input logic hsv,
                              input logic [7:0] cvd, input logic [7:0] hsd);
        exp_t       e;
        bit         have;
        logic [1:0] obs;
        obs  = {cvv, hsv};
        have = (d == 1) ? (q1.size() != 0) : (q2.size() != 0);
        if (have) e = (d == 1) ? q1[0] : q2[0];
        if (obs != 2'b00 || (have && e.due <= cyc)) begin
            if (!have) begin
                checkOutput($sformatf("d%0d_unexpected_rvalid", d), obs, 2'b00);
            end else begin
                if (d == 1) void'(q1.pop_front());
                else        void'(q2.pop_front());
                checkOutput($sformatf("d%0d_rvalid_target", d), obs, e.tgt);
                checkOutput($sformatf("d%0d_rvalid_cycle", d), cyc, e.due);
                if (obs != 2'b00)
                    checkOutput($sformatf("d%0d_rdata", d), cvv ? cvd : hsd, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            monitorDut(1, d1_cv_rvalid, d1_hs_rvalid, d1_cv_rdata, d1_hs_rdata);
            monitorDut(2, d2_cv_rvalid, d2_hs_rvalid, d2_cv_rdata, d2_hs_rdata);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seqLock[7];
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        checkCmd("reset", 0, 0, 0, 0);
        checkOutput("reset_d1_regcea", d1_regcea, 0);
        checkOutput("reset_d1_busy", d1_busy, 0);
        checkOutput("reset_d1_rvalid", {d1_cv_rvalid, d1_hs_rvalid}, 0);
        checkOutput("reset_d2_busy", d2_busy, 0);
        checkOutput("reset_d2_rvalid", {d2_cv_rvalid, d2_hs_rvalid}, 0);
        @(negedge clk);
        reset = 1'b1;
        stepClk;
        checkOutput("run_d1_regcea", d1_regcea, 1);
        checkOutput("run_d2_regcea", d2_regcea, 1);

        $display("[TB] single write");
        applyStimulus(1, 16'd5, 8'hA5, 0, 0, 0, 0, 0);
        #1;
        checkReady("wr", 0);
        stepClk;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCmd("wr_cmd", 1, 1, 16'd5, 8'hA5);
        checkOutput("wr_d1_busy", d1_busy, 1);
        stepClk;
        checkCmd("wr_idle", 0, 0, 16'd5, 8'hA5);
        checkOutput("wr_idle_d1_busy", d1_busy, 0);

        $display("[TB] read after write");
        applyStimulus(0, 0, 0, 1, 16'd5, 0, 0, 0);
        #1;
        checkReady("raw", 1);
        expectRead(2'b10, 8'hA5);
        stepClk;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkCmd("raw_cmd", 1, 0, 16'd5, 8'hA5);
        repeat (5) stepClk;

        $display("[TB] fairness");
        doReset;
        expDin = 8'hA5;
        for (int k = 0; k < 6; k++) begin
            int g;
            g = k % 3;
            applyStimulus(1, seqAddr(0, k), 8'h40 + 8'(k), 1, seqAddr(1, k), 0, 1, seqAddr(2, k));
            #1;
            checkReady($sformatf("rr%0d", k), g);
            if (g == 0) expDin = 8'h40 + 8'(k);
            if (g == 1) expectRead(2'b10, 8'h10 + 8'(k));
            if (g == 2) expectRead(2'b01, 8'h10 + 8'(k));
            stepClk;
            checkCmd($sformatf("rr%0d_cmd", k), 1, g == 0, seqAddr(g, k), expDin);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) stepClk;

        $display("[TB] lock bound");
        doReset;
        seqLock = '{0, 1, 3, 1, 1, 2, 0};
        for (int k = 0; k < 7; k++) begin
            int g;
            g = seqLock[k];
            applyStimulus(1, seqAddr(0, k), 8'h40 + 8'(k), k != 2, seqAddr(1, k), 1, 1, seqAddr(2, k));
            #1;
            checkReady($sformatf("lk%0d", k), g);
            if (g == 0) expDin = 8'h40 + 8'(k);
            if (g == 1) expectRead(2'b10, 8'h10 + 8'(k));
            if (g == 2) expectRead(2'b01, 8'h10 + 8'(k));
            if (g != 3) expAddr = seqAddr(g, k);
            stepClk;
            checkCmd($sformatf("lk%0d_cmd", k), g != 3, g == 0, expAddr, expDin);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) stepClk;

        $display("[TB] pipelined host reads");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1, AW'(k));
            #1;
            checkReady($sformatf("hs%0d", k), 2);
            expectRead(2'b01, 8'h10 + 8'(k));
            stepClk;
            checkCmd($sformatf("hs%0d_cmd", k), 1, 0, AW'(k), expDin);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (6) stepClk;

        $display("[TB] reset during read");
        applyStimulus(0, 0, 0, 1, 16'h0100, 0, 0, 0);
        #1;
        checkReady("rst", 1);
        stepClk;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        stepClk;
        checkOutput("rst_pre_d1_busy", d1_busy, 1);
        checkOutput("rst_pre_d2_busy", d2_busy, 1);
        reset = 1'b0;
        q1.delete();
        q2.delete();
        #1;
        checkOutput("rst_d1_rvalid", {d1_cv_rvalid, d1_hs_rvalid}, 0);
        checkOutput("rst_d2_rvalid", {d2_cv_rvalid, d2_hs_rvalid}, 0);
        checkOutput("rst_d1_ena_busy", {d1_ena, d1_busy}, 0);
        checkOutput("rst_d2_ena_busy", {d2_ena, d2_busy}, 0);
        repeat (2) stepClk;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) stepClk;

        checkOutput("d1_pending_reads", q1.size(), 0);
        checkOutput("d2_pending_reads", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
